// File: rtl/cpu_pkg.sv
// Shared constants for the CPU flow path: widths, flow opcodes, SR bit indices,
// and the flow control FSM state encoding.
package cpu_pkg;

  localparam int unsigned WORD_W = 20;
  localparam int unsigned HALF_W = 10;

  localparam int unsigned SR_Z = 0;
  localparam int unsigned SR_S = 1;
  localparam int unsigned SR_C = 2;
  localparam int unsigned SR_T = 3;

  typedef enum logic [2:0] {
    OP_TRAP = 3'd0,
    OP_NOP  = 3'd1,
    OP_JMP  = 3'd2,
    OP_JZ   = 3'd3,
    OP_JS   = 3'd4,
    OP_JZS  = 3'd5,
    OP_LDSR = 3'd6,
    OP_XSR  = 3'd7
  } op_code_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_TRAP = 2'd2
  } flow_state_t;

endpackage

// File: rtl/flow_ctrl_unit_if.sv
// Decoder/ALU-facing signal bundle of the flow control unit.
interface flow_ctrl_unit_if #(
  parameter int unsigned WORD_W = cpu_pkg::WORD_W
);
  logic              flag_valid;
  logic              alu_zero;
  logic              alu_sign;
  logic              alu_carry;
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op_code;
  logic              op_mode;
  logic [WORD_W-1:0] op_operand;
  logic              pc_inc;
  logic              trap_clr;
  logic [WORD_W-1:0] pc;
  logic [3:0]        sr;
  logic              branch_taken;
  logic              trap;

  // Decoder / ALU side
  modport master (
    output flag_valid, alu_zero, alu_sign, alu_carry,
    output op_valid, op_code, op_mode, op_operand, pc_inc, trap_clr,
    input  op_ready, pc, sr, branch_taken, trap
  );

  // Flow control unit side
  modport slave (
    input  flag_valid, alu_zero, alu_sign, alu_carry,
    input  op_valid, op_code, op_mode, op_operand, pc_inc, trap_clr,
    output op_ready, pc, sr, branch_taken, trap
  );
endinterface

// File: rtl/flow_cond_eval.sv
// Combinational branch decision and jump target formation for a latched flow op.
module flow_cond_eval
  import cpu_pkg::*;
#(
  parameter int unsigned WORD_W = cpu_pkg::WORD_W,
  parameter int unsigned HALF_W = cpu_pkg::HALF_W
) (
  input  op_code_t          op_code,
  input  logic              op_mode,
  input  logic [WORD_W-1:0] operand,
  input  logic              sr_z,
  input  logic              sr_s,
  output logic              taken,
  output logic [WORD_W-1:0] target
);

  // Branch condition from the status flags held at the start of EXEC
  always_comb begin
    taken = 1'b0;
    case (op_code)
      OP_JMP:  taken = 1'b1;
      OP_JZ:   taken = sr_z;
      OP_JS:   taken = sr_s;
      OP_JZS:  taken = sr_z | sr_s;
      default: taken = 1'b0;
    endcase
  end

  // Full mode jumps to the whole operand; half mode zero-extends the low half
  always_comb begin
    target = op_mode ? operand : {{(WORD_W-HALF_W){1'b0}}, operand[HALF_W-1:0]};
  end

endmodule

// File: rtl/flow_ctrl_unit.sv
// Flow control unit: status register capture, flow opcode execution and PC ownership.
module flow_ctrl_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       WORD_W   = cpu_pkg::WORD_W,
  parameter int unsigned       HALF_W   = cpu_pkg::HALF_W,
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input logic              clk,
  input logic              rst,
  flow_ctrl_unit_if.slave  bus
);

  flow_state_t       state;
  op_code_t          op_code_q;
  logic              op_mode_q;
  logic [WORD_W-1:0] operand_q;
  logic [WORD_W-1:0] pc_q;
  logic [3:0]        sr_q;
  logic              branch_q;
  logic              trap_q;
  logic              taken;
  logic [WORD_W-1:0] target;
  logic              sr_op;

  flow_cond_eval #(
    .WORD_W (WORD_W),
    .HALF_W (HALF_W)
  ) u_cond (
    .op_code (op_code_q),
    .op_mode (op_mode_q),
    .operand (operand_q),
    .sr_z    (sr_q[SR_Z]),
    .sr_s    (sr_q[SR_S]),
    .taken   (taken),
    .target  (target)
  );

  // SR-writing ops take priority over ALU flags in their EXEC cycle
  always_comb begin
    sr_op = (op_code_q == OP_LDSR) || (op_code_q == OP_XSR);
  end

  // FSM with PC, SR and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_code_q <= OP_NOP;
      op_mode_q <= 1'b0;
      operand_q <= '0;
      pc_q      <= RESET_PC;
      sr_q      <= '0;
      branch_q  <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      branch_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.flag_valid)
            sr_q[2:0] <= {bus.alu_carry, bus.alu_sign, bus.alu_zero};
          if (bus.pc_inc)
            pc_q <= pc_q + WORD_W'(1);
          if (bus.op_valid) begin
            op_code_q <= op_code_t'(bus.op_code);
            op_mode_q <= bus.op_mode;
            operand_q <= bus.op_operand;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state <= ST_IDLE;
          if (bus.flag_valid && !sr_op)
            sr_q[2:0] <= {bus.alu_carry, bus.alu_sign, bus.alu_zero};
          case (op_code_q)
            OP_TRAP: begin
              state      <= ST_TRAP;
              trap_q     <= 1'b1;
              sr_q[SR_T] <= 1'b1;
            end
            OP_LDSR: sr_q[2:0] <= operand_q[2:0];
            OP_XSR:  sr_q[2:0] <= sr_q[2:0] ^ operand_q[2:0];
            default: begin
              if (taken) begin
                pc_q     <= target;
                branch_q <= 1'b1;
              end
            end
          endcase
        end
        ST_TRAP: begin
          if (bus.trap_clr) begin
            state      <= ST_IDLE;
            trap_q     <= 1'b0;
            sr_q[SR_T] <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.op_ready     = (state == ST_IDLE);
  assign bus.pc           = pc_q;
  assign bus.sr           = sr_q;
  assign bus.branch_taken = branch_q;
  assign bus.trap         = trap_q;

endmodule

// File: tb/tb_flow_ctrl_unit.sv
// Scoreboard bench for flow_ctrl_unit: a transaction-level model predicts the
// visible state after every clock edge; a monitor pops and compares.
module tb_flow_ctrl_unit;
  import cpu_pkg::*;

  typedef struct {
    logic [19:0] pc;
    logic [3:0]  sr;
    logic        bt;
    logic        trap;
    logic        rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  flow_ctrl_unit_if #(.WORD_W(20)) bus ();

  flow_ctrl_unit #(
    .WORD_W   (20),
    .HALF_W   (10),
    .RESET_PC (20'h00000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: halted / op-pending view of the unit
  logic [19:0] m_pc;
  logic [3:0]  m_sr;
  logic        m_bt;
  bit          m_halted;
  bit          m_pending;
  logic [2:0]  m_code;
  logic        m_mode;
  logic [19:0] m_opnd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 20'h0; m_sr = 4'h0; m_bt = 1'b0;
    m_halted = 0; m_pending = 0;
  endtask

  // Predict effect of the coming clock edge from the inputs currently driven
  task automatic model_edge();
    logic [3:0] sr0;
    bit         take;
    sr0  = m_sr;
    m_bt = 1'b0;
    if (rst) begin
      model_reset();
    end else if (m_halted) begin
      if (bus.trap_clr) begin
        m_halted = 0;
        m_sr[3]  = 1'b0;
      end
    end else if (m_pending) begin
      m_pending = 0;
      if (bus.flag_valid && m_code != 3'd6 && m_code != 3'd7)
        m_sr[2:0] = {bus.alu_carry, bus.alu_sign, bus.alu_zero};
      take = (m_code == 3'd2) || (m_code == 3'd3 && sr0[0]) ||
             (m_code == 3'd4 && sr0[1]) || (m_code == 3'd5 && (sr0[0] || sr0[1]));
      if (m_code == 3'd0) begin
        m_halted = 1;
        m_sr[3]  = 1'b1;
      end else if (m_code == 3'd6) begin
        m_sr[2:0] = m_opnd[2:0];
      end else if (m_code == 3'd7) begin
        m_sr[2:0] = sr0[2:0] ^ m_opnd[2:0];
      end else if (take) begin
        m_pc = m_mode ? m_opnd : (m_opnd % 20'h400);
        m_bt = 1'b1;
      end
    end else begin
      if (bus.flag_valid)
        m_sr[2:0] = {bus.alu_carry, bus.alu_sign, bus.alu_zero};
      if (bus.pc_inc)
        m_pc = 20'((int'(m_pc) + 1) % (1 << 20));
      if (bus.op_valid) begin
        m_pending = 1;
        m_code = bus.op_code;
        m_mode = bus.op_mode;
        m_opnd = bus.op_operand;
      end
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.pc   = m_pc;
    e.sr   = m_sr;
    e.bt   = m_bt;
    e.trap = m_halted;
    e.rdy  = !m_halted && !m_pending;
    exp_q.push_back(e);
  endtask

  task automatic quiet();
    bus.flag_valid = 0; bus.alu_zero = 0; bus.alu_sign = 0; bus.alu_carry = 0;
    bus.op_valid = 0; bus.op_code = 3'd1; bus.op_mode = 0; bus.op_operand = '0;
    bus.pc_inc = 0; bus.trap_clr = 0;
  endtask

  task automatic set_op(input logic [2:0] code, input logic mode, input logic [19:0] opnd);
    bus.op_valid = 1; bus.op_code = code; bus.op_mode = mode; bus.op_operand = opnd;
  endtask

  task automatic set_flags(input logic c, input logic s, input logic z);
    bus.flag_valid = 1; bus.alu_carry = c; bus.alu_sign = s; bus.alu_zero = z;
  endtask

  // Inputs are set by the caller before the negedge wait returns control here
  task automatic cycle();
    model_edge();
    push_expect();
    @(posedge clk);
    #3;
    quiet();
  endtask

  // Monitor: compare the DUT after every edge for which a prediction exists
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc", 32'(bus.pc), 32'(e.pc));
      chk("sr", 32'(bus.sr), 32'(e.sr));
      chk("branch_taken", 32'(bus.branch_taken), 32'(e.bt));
      chk("trap", 32'(bus.trap), 32'(e.trap));
      chk("op_ready", 32'(bus.op_ready), 32'(e.rdy));
    end
  end

  initial begin
    quiet();
    model_reset();
    rst = 1;
    @(negedge clk); cycle();
    chk("reset_op_ready", 32'(bus.op_ready), 32'd1);
    @(negedge clk); rst = 0; cycle();

    // Async reset in the middle of a JMP EXEC
    @(negedge clk); set_op(3'd2, 1, 20'h12345); cycle();
    #2; rst = 1; model_reset(); #1;
    chk("midexec_rst_pc", 32'(bus.pc), 32'h0);
    chk("midexec_rst_sr", 32'(bus.sr), 32'h0);
    chk("midexec_rst_ready", 32'(bus.op_ready), 32'd1);
    chk("midexec_rst_bt", 32'(bus.branch_taken), 32'd0);
    @(negedge clk); cycle();
    @(negedge clk); rst = 0; cycle();
    chk("after_rst_pc", 32'(bus.pc), 32'h0);

    // JZ taken then not taken
    @(negedge clk); set_flags(0, 0, 1); cycle();
    @(negedge clk); set_op(3'd3, 1, 20'h0ABCD); cycle();
    @(negedge clk); cycle();
    chk("jz_taken_pc", 32'(bus.pc), 32'h0ABCD);
    chk("jz_taken_pulse", 32'(bus.branch_taken), 32'd1);
    @(negedge clk); set_flags(0, 0, 0); cycle();
    chk("jz_pulse_end", 32'(bus.branch_taken), 32'd0);
    @(negedge clk); set_op(3'd3, 1, 20'h00055); cycle();
    @(negedge clk); cycle();
    chk("jz_not_taken_pc", 32'(bus.pc), 32'h0ABCD);
    chk("jz_not_taken_pulse", 32'(bus.branch_taken), 32'd0);

    // JS half mode, JZS not taken
    @(negedge clk); set_flags(0, 1, 0); cycle();
    @(negedge clk); set_op(3'd4, 0, 20'hFFFFF); cycle();
    @(negedge clk); cycle();
    chk("js_half_pc", 32'(bus.pc), 32'h003FF);
    @(negedge clk); set_flags(0, 0, 0); cycle();
    @(negedge clk); set_op(3'd5, 1, 20'h11111); cycle();
    @(negedge clk); cycle();
    chk("jzs_not_taken_pc", 32'(bus.pc), 32'h003FF);

    // PC wrap and pc_inc together with op acceptance
    @(negedge clk); set_op(3'd2, 1, 20'hFFFFF); cycle();
    @(negedge clk); cycle();
    @(negedge clk); bus.pc_inc = 1; cycle();
    chk("pc_wrap", 32'(bus.pc), 32'h00000);
    @(negedge clk); cycle();
    @(negedge clk); set_op(3'd2, 1, 20'hFFFFF); cycle();
    @(negedge clk); cycle();
    @(negedge clk); bus.pc_inc = 1; set_op(3'd2, 1, 20'h00010); cycle();
    chk("inc_with_op_pc", 32'(bus.pc), 32'h00000);
    @(negedge clk); bus.pc_inc = 1; cycle();
    chk("jmp_after_inc_pc", 32'(bus.pc), 32'h00010);

    // SR ops
    @(negedge clk); set_op(3'd6, 1, 20'h00007); cycle();
    @(negedge clk); set_flags(0, 0, 0); cycle();
    chk("ldsr_beats_flags", 32'(bus.sr), 32'h7);
    @(negedge clk); set_op(3'd7, 0, 20'h00005); cycle();
    @(negedge clk); cycle();
    chk("xsr", 32'(bus.sr), 32'h2);
    @(negedge clk); set_op(3'd6, 1, 20'h0000F); cycle();
    @(negedge clk); cycle();
    chk("ldsr_t_protected", 32'(bus.sr), 32'h7);

    // TRAP and recovery
    @(negedge clk); set_op(3'd0, 1, 20'h0); cycle();
    @(negedge clk); cycle();
    chk("trap_level", 32'(bus.trap), 32'd1);
    chk("trap_sr", 32'(bus.sr), 32'hF);
    chk("trap_ready", 32'(bus.op_ready), 32'd0);
    @(negedge clk); bus.pc_inc = 1; set_flags(0, 0, 0); set_op(3'd2, 1, 20'h00AAA); cycle();
    chk("trap_pc_frozen", 32'(bus.pc), 32'h00010);
    chk("trap_sr_frozen", 32'(bus.sr), 32'hF);
    @(negedge clk); bus.trap_clr = 1; cycle();
    chk("trap_clr_trap", 32'(bus.trap), 32'd0);
    chk("trap_clr_sr", 32'(bus.sr), 32'h7);
    @(negedge clk); set_op(3'd2, 1, 20'h00321); cycle();
    @(negedge clk); cycle();
    chk("post_trap_jmp", 32'(bus.pc), 32'h00321);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      bus.flag_valid = $urandom_range(0, 1);
      bus.alu_zero = $urandom_range(0, 1);
      bus.alu_sign = $urandom_range(0, 1);
      bus.alu_carry = $urandom_range(0, 1);
      bus.op_valid = $urandom_range(0, 1);
      bus.op_code = 3'($urandom_range(0, 7));
      bus.op_mode = $urandom_range(0, 1);
      bus.op_operand = 20'($urandom);
      bus.pc_inc = $urandom_range(0, 1);
      bus.trap_clr = ($urandom_range(0, 3) == 0);
      cycle();
    end
    rst = 0;

    @(negedge clk); cycle();
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
